// File: rtl/lpc_sniffer_pkg.sv
// Shared types and constants for the LPC sniffer capture path.
package lpc_sniffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } drain_state_t;

  localparam int REC_BYTES_DEFAULT = 6;
  localparam int GUARD_DEFAULT     = 3;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/ringbuffer_drain_if.sv
// Drain-side bundle: ring-buffer pointer/RAM read port plus transmitter byte stream.
interface ringbuffer_drain_if #(
  parameter int BITS      = 5,
  parameter int REC_BYTES = 6
);
  logic                   empty;
  logic [BITS-1:0]        read_addr;
  logic [BITS-1:0]        mem_addr;
  logic                   mem_rd;
  logic [8*REC_BYTES-1:0] mem_data;
  logic                   read_done;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (
    input  empty, read_addr, mem_data, tx_ready,
    output mem_addr, mem_rd, read_done, tx_data, tx_valid
  );

  modport slave (
    output empty, read_addr, mem_data, tx_ready,
    input  mem_addr, mem_rd, read_done, tx_data, tx_valid
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous flag; reset value is a parameter.
// Latency 2 clk; no backpressure.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ringbuffer_drain.sv
// Ring-buffer drain: fetch one record, stream it MSB-first (ASCII hex + CRLF under RINGBUFFER_DRAIN_HEX_EN).
// First tx_valid 3 clk after non-empty seen; tx_data/tx_valid held while tx_ready low.
module ringbuffer_drain
  import lpc_sniffer_pkg::*;
#(
  parameter int BITS      = 5,
  parameter int REC_BYTES = REC_BYTES_DEFAULT,
  parameter int GUARD     = GUARD_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  ringbuffer_drain_if.master bus
);
`ifdef RINGBUFFER_DRAIN_HEX_EN
  localparam int NXFER = 2*REC_BYTES + 2;
`else
  localparam int NXFER = REC_BYTES;
`endif
  localparam int CW = $clog2(NXFER + 1);
  localparam int GW = $clog2(GUARD + 2);
  localparam int RW = 8*REC_BYTES;
  localparam logic [CW-1:0] LAST = CW'(NXFER - 1);

  drain_state_t    state, state_nxt;
  logic            empty_s;
  logic [BITS-1:0] mem_addr_q;
  logic [RW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   guard;
  logic            xfer;
  logic [7:0]      cur_byte;

  sync2 #(.RESET_VAL(1'b1)) u_empty_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.empty),
    .q     (empty_s)
  );

  assign xfer = (state == SEND) && bus.tx_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (guard == '0 && !empty_s) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (xfer && cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr_q <= '0;
      shreg      <= '0;
      cnt        <= '0;
      guard      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) mem_addr_q <= bus.read_addr;
      // Guard masks the stale empty flag until the pointer update has crossed the synchronizer.
      if (state == DONE)     guard <= GW'(GUARD);
      else if (guard != '0)  guard <= guard - GW'(1);
      if (state == LOAD) begin
        shreg <= bus.mem_data;
        cnt   <= '0;
      end else if (xfer) begin
        cnt <= cnt + CW'(1);
`ifdef RINGBUFFER_DRAIN_HEX_EN
        if (cnt[0]) shreg <= shreg << 8;
`else
        shreg <= shreg << 8;
`endif
      end
    end
  end

`ifdef RINGBUFFER_DRAIN_HEX_EN
  // Even counts carry the high nibble; the last two transfers are CR, LF.
  always_comb begin
    if (cnt >= CW'(2*REC_BYTES)) cur_byte = cnt[0] ? 8'h0A : 8'h0D;
    else cur_byte = hex_ascii(cnt[0] ? shreg[RW-5 -: 4] : shreg[RW-1 -: 4]);
  end
`else
  assign cur_byte = shreg[RW-1 -: 8];
`endif

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = (state == FETCH);
  assign bus.read_done = (state == DONE);
  assign bus.tx_valid  = (state == SEND);
  assign bus.tx_data   = (state == SEND) ? cur_byte : 8'h00;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Bench for ringbuffer_drain: pointer-block/RAM model, per-record byte scoreboard, literal pins.
module tb_ringbuffer_drain;
  localparam int BITS  = 5;
  localparam int RB    = 6;
  localparam int GUARD = 3;
  localparam int DEPTH = 1 << BITS;
`ifdef RINGBUFFER_DRAIN_HEX_EN
  localparam int NX = 2*RB + 2;
`else
  localparam int NX = RB;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ringbuffer_drain_if #(.BITS(BITS), .REC_BYTES(RB)) bus();

  ringbuffer_drain #(.BITS(BITS), .REC_BYTES(RB), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Record -> transmitted characters, straight from the stream format rules.
  function automatic bq_t expand(input logic [8*RB-1:0] rec);
    bq_t q;
    logic [7:0] b;
    q = {};
    for (int i = 0; i < RB; i++) begin
      b = rec[8*(RB-1-i) +: 8];
`ifdef RINGBUFFER_DRAIN_HEX_EN
      q.push_back((b[7:4] < 10) ? 8'h30 + b[7:4] : 8'h41 + (b[7:4] - 4'd10));
      q.push_back((b[3:0] < 10) ? 8'h30 + b[3:0] : 8'h41 + (b[3:0] - 4'd10));
`else
      q.push_back(b);
`endif
    end
`ifdef RINGBUFFER_DRAIN_HEX_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
    return q;
  endfunction

  // Pointer block + buffer RAM model
  logic [8*RB-1:0] ram [DEPTH];
  logic [BITS-1:0] rd_ptr = '0;
  logic [BITS-1:0] wr_ptr = '0;
  logic [BITS-1:0] ptr_val = '0;
  logic            ptr_set = 1'b0;

  always @(posedge clk) begin
    if (ptr_set) rd_ptr <= ptr_val;
    else if (bus.read_done) rd_ptr <= rd_ptr + 1'b1;
  end

  assign bus.empty     = (rd_ptr == wr_ptr);
  assign bus.read_addr = rd_ptr;

  // Off-cycle RAM output is junk so a mistimed capture shows up.
  always @(posedge clk) begin
    bus.mem_data <= bus.mem_rd ? ram[bus.mem_addr] : (8*RB)'({$urandom(), $urandom()});
  end

  // Scoreboard state (written by the compare process)
  bq_t        cur_exp;
  bq_t        log_q;
  int         addr_log[$];
  logic       in_rec = 1'b0;
  logic       first_seen = 1'b0;
  logic       have_done = 1'b0;
  logic       prev_hold = 1'b0;
  logic       prev_rd = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         cyc = 0, rd_cyc = 0, last_xfer_cyc = 0, last_done_cyc = 0;
  int         nsent = 0, done_cnt = 0, rd_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_mem_rd", bus.mem_rd, 1'b0);
      chk("rst_read_done", bus.read_done, 1'b0);
      in_rec = 1'b0; cur_exp = {}; prev_hold = 1'b0; prev_rd = 1'b0; have_done = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.tx_valid, 1'b1);
        chk("hold_data", bus.tx_data, prev_data);
      end
      if (bus.mem_rd) begin
        rd_cnt++;
        addr_log.push_back(int'(bus.mem_addr));
        chk("mem_rd_pulse", prev_rd, 1'b0);
        chk("mem_rd_busy", in_rec, 1'b0);
        chk("mem_rd_nonempty", rd_ptr != wr_ptr, 1'b1);
        chk("mem_addr", bus.mem_addr, rd_ptr);
        // DONE loads GUARD; IDLE needs it back at 0, so FETCH is >= GUARD+2 cycles after read_done.
        if (have_done) chk("guard_gap", (cyc - last_done_cyc) >= GUARD + 2, 1'b1);
        cur_exp = expand(ram[rd_ptr]);
        in_rec = 1'b1; first_seen = 1'b0; rd_cyc = cyc; nsent = 0;
      end
      prev_rd = bus.mem_rd;
      if (bus.tx_valid) begin
        if (!first_seen) begin
          chk("first_latency", cyc - rd_cyc, 2);
          first_seen = 1'b1;
        end
        chk("tx_in_record", in_rec && cur_exp.size() > 0, 1'b1);
        if (bus.tx_ready && cur_exp.size() > 0) begin
          chk("tx_data", bus.tx_data, cur_exp[0]);
          void'(cur_exp.pop_front());
          log_q.push_back(bus.tx_data);
          nsent++;
          last_xfer_cyc = cyc;
        end
      end
      prev_hold = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      if (bus.read_done) begin
        chk("done_complete", in_rec && cur_exp.size() == 0 && nsent == NX, 1'b1);
        chk("done_timing", cyc - last_xfer_cyc, 1);
        done_cnt++; in_rec = 1'b0; have_done = 1'b1; last_done_cyc = cyc;
      end
    end
  end

  // tx_ready driver: 0 = always ready, 1 = 1,0,0 pattern, 2 = random
  int rdy_mode = 0;
  initial begin
    int pat;
    pat = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.tx_ready = (pat % 3 == 0);
        2:       bus.tx_ready = ($urandom_range(0, 3) != 0);
        default: bus.tx_ready = 1'b1;
      endcase
      pat++;
    end
  end

  task automatic push(input logic [8*RB-1:0] rec);
    ram[wr_ptr] = rec;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic clear_logs();
    log_q = {}; addr_log = {}; done_cnt = 0; rd_cnt = 0;
  endtask

  task automatic do_reset(input logic [BITS-1:0] p);
    reset = 1'b0; ptr_val = p; ptr_set = 1'b1; wr_ptr = p;
    repeat (2) @(posedge clk);
    #1; ptr_set = 1'b0; reset = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((rd_ptr != wr_ptr || in_rec) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, n < budget, 1'b1);
    repeat (GUARD + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_literal(input string name, input bq_t lit);
    chk({name, "_len"}, log_q.size(), lit.size());
    for (int i = 0; i < lit.size(); i++) chk({name, "_byte"}, log_q[i], lit[i]);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_rd"}, rd_cnt, 1);
  endtask

  initial begin
    bq_t lit;
    logic [8*RB-1:0] rec1;
    logic [8*RB-1:0] ra, rb;
    logic [63:0] r;
    int n;
`ifdef RINGBUFFER_DRAIN_HEX_EN
    rec1 = 48'hA1B2C3D4E5F6;
    lit = '{8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33, 8'h44, 8'h34,
            8'h45, 8'h35, 8'h46, 8'h36, 8'h0D, 8'h0A};
`else
    rec1 = 48'h010203040506;
    lit = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`endif

    // Reset, then idle with empty=1
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_mem_rd", bus.mem_rd, 1'b0);
      chk("idle_tx_valid", bus.tx_valid, 1'b0);
      chk("idle_read_done", bus.read_done, 1'b0);
    end
    @(posedge clk); #1;

    // Single record at address 5, always ready
    do_reset(5);
    clear_logs();
    push(rec1);
    wait_drain("single_timeout", 100);
    check_literal("single", lit);
    chk("single_addr", addr_log[0], 5);

    // Backpressure 1,0,0,...
    clear_logs();
    rdy_mode = 1;
    push(rec1);
    wait_drain("bp_timeout", 200);
    check_literal("bp", lit);
    rdy_mode = 0;

    // Wrap 31 -> 0, back to back
    do_reset(31);
    clear_logs();
    ra = 48'h1122_3344_5566;
    rb = 48'hF0E1_D2C3_B4A5;
    push(ra);
    push(rb);
    wait_drain("wrap_timeout", 200);
    chk("wrap_recs", done_cnt, 2);
    chk("wrap_addr0", addr_log[0], 31);
    chk("wrap_addr1", addr_log[1], 0);
    chk("wrap_len", log_q.size(), 2*NX);
    chk("wrap_second_first", log_q[NX], expand(rb)[0]);

    // Reset mid-record after the third transfer
    do_reset(10);
    clear_logs();
    push(rec1);
    n = 0;
    while (!(in_rec && nsent >= 3) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach", n < 200, 1'b1);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("abort_tx_valid", bus.tx_valid, 1'b0);
    chk("abort_partial", log_q.size(), 3);
    chk("abort_no_done", done_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_logs();
    wait_drain("resend_timeout", 100);
    check_literal("resend", lit);
    chk("resend_addr", addr_log[0], 10);

    // Randomized records, random gaps and random tx_ready
    do_reset(BITS'($urandom_range(0, DEPTH - 1)));
    clear_logs();
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #1;
      n = 0;
      while (BITS'(wr_ptr - rd_ptr) > 28 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      r = {$urandom(), $urandom()};
      push(r[8*RB-1:0]);
    end
    wait_drain("rand_timeout", 3000);
    chk("rand_recs", done_cnt, 24);
    chk("rand_bytes", log_q.size(), 24*NX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ringbuffer_drain.md
Name: ringbuffer_drain

Overview:
- Consumer end of the capture ring buffer.
- Whenever the ring-buffer pointer block reports non-empty, reads one LPC capture record from buffer RAM at the current read address and serializes it into bytes on a valid/ready byte stream (feeds the UART transmitter).
- Pulses read_done to advance the read pointer.
- Runs on the host/UART clock; the empty flag arrives from the capture side and is synchronized internally.

Parameters:
- BITS, 5, ring-buffer address width (depth 2^BITS records).
- REC_BYTES, 6, bytes per capture record (record width 8*REC_BYTES).
- GUARD, 3, clk cycles after read_done during which empty is ignored (covers pointer update plus 2-flop sync).

Ports:
- clk  input  1  host/UART clock.
- reset  input  1  asynchronous, active-low.
- empty  input  1  ring-buffer empty flag, asynchronous to clk.
- read_addr  input  BITS  current ring-buffer read pointer.
- mem_addr  output  BITS  buffer RAM read address.
- mem_rd  output  1  RAM read strobe; data is valid one cycle later.
- mem_data  input  8*REC_BYTES  RAM read data.
- read_done  output  1  one-cycle high pulse: record consumed.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts the byte this cycle.

Behaviour:
- Reset (asynchronous, active-low) values:
  - state=IDLE; mem_addr=0, mem_rd=0, read_done=0, tx_data=0, tx_valid=0.
  - Sync flops=1 (treated as empty); byte counter=0; guard counter=0.
- empty passes through a 2-flop synchronizer reset to 1. Only the synchronized value (empty_s) is used.
- FSM states:
  - IDLE: if guard counter==0 and empty_s==0, go to FETCH. mem_addr<=read_addr.
  - FETCH: mem_rd=1 for exactly one cycle, then go to LOAD.
  - LOAD: capture mem_data into the shift register; byte counter=0; go to SEND.
  - SEND: tx_valid=1, tx_data = current byte, most-significant byte first.
    - A byte transfers on a cycle with tx_valid and tx_ready both high.
    - On transfer: if this was byte REC_BYTES-1, go to DONE; otherwise advance to the next byte in the following cycle.
    - tx_data and tx_valid are held stable while tx_ready is low (no retraction).
  - DONE: read_done=1 for one cycle; guard counter loads GUARD; go to IDLE.
- Guard counter decrements each cycle while nonzero.
- Throughput: minimum REC_BYTES+3 cycles per record, plus GUARD cycles before the next fetch.
- Byte stream latency: first tx_valid appears 3 cycles after IDLE sees empty_s=0.
- Boundary conditions:
  - Read-pointer wrap is owned by the pointer block. mem_addr is simply copied, so 2^BITS-1 → 0 needs no special handling.
  - empty rising mid-record (impossible by protocol) is ignored; the record completes.
  - empty_s falling during the guard window is acted on only after the guard expires.
  - Reset asserted mid-record drops the partial record. tx_valid is low on the cycle after reset assertion; no read_done is issued.
  - tx_ready high while tx_valid low has no effect.

Optional Feature:
- Macro: RINGBUFFER_DRAIN_HEX_EN.
- Defined:
  - Each record byte is emitted as two ASCII hex characters, high nibble first, '0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46.
  - Each record is followed by 0x0D 0x0A.
  - Total 2*REC_BYTES+2 transfers per record; the byte counter widens accordingly.
- Undefined: raw binary, REC_BYTES transfers per record, no terminator.

Decomposition:
- Shared package lpc_sniffer_pkg:
  - State enum type drain_state_t (IDLE, FETCH, LOAD, SEND, DONE).
  - Constants REC_BYTES_DEFAULT=6 and GUARD_DEFAULT=3.
  - Hex-to-ASCII function, used under the macro.
- Sub-module sync2: a 2-flop synchronizer with async active-low reset and parameterized reset value. It is reused for any other cross-domain flag.

Test Plan:
- Reset with empty=1: hold 10 cycles → no mem_rd, tx_valid=0, read_done=0 throughout.
- Single record:
  - Stimulus: read_addr=5, mem_data=0x0102_0304_0506, empty falls, tx_ready=1.
  - Required response: mem_addr=5, one mem_rd pulse; bytes 01,02,03,04,05,06 on consecutive cycles; one read_done pulse after byte 06.
- Backpressure: same record with tx_ready toggling 1,0,0,1,... → tx_data held stable while tx_ready=0; exactly 6 transfers in order; no duplicates.
- Wrap plus back-to-back:
  - Stimulus: model pointer block. Records at addresses 31 and 0; empty stays 0 until the second read_done.
  - Required response: two records sent in order, mem_addr 31 then 0, next fetch at least GUARD cycles after the first read_done.
- Reset mid-record: assert reset after byte 3 → tx_valid=0 next cycle, no read_done, FSM in IDLE; re-sending after release starts from byte 01.
- With RINGBUFFER_DRAIN_HEX_EN: mem_data=0xA1B2C3D4E5F6 → stream 41 31 42 32 43 33 44 34 45 35 46 36 0D 0A, then one read_done.
